mem_arb: RTL and testbench
==========================

Name: mem_arb

Overview:
- Two-master arbiter and sequencer for the single unified memory port of the multicycle CPU.
- Master 0 is the CPU memory port (adr/MemWrite/writedata/readdata). Master 1 is the debug/program-loader port.
- Serialises accesses, drives the synchronous memory with a fixed read latency, and returns one-cycle acknowledges.
- The CPU control stalls its memory state until m0_ack.

Parameters:
- RD_LAT, 1, memory read latency in cycles from the address-capture edge to valid mem_rdata; legal range 1..4.
- FIXED_PRI, 0, 0 = round-robin between masters; 1 = master 0 always wins ties.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- m0_req  in  1  master 0 request, held until m0_ack
- m0_we  in  1  master 0 write (1) / read (0)
- m0_adr  in  32  master 0 byte address
- m0_wdata  in  32  master 0 write data
- m0_rdata  out  32  master 0 read data, held
- m0_ack  out  1  master 0 completion, one-cycle pulse
- m1_req, m1_we, m1_adr, m1_wdata, m1_rdata, m1_ack  same widths/directions, master 1
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_adr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data
- busy  out  1  state != IDLE
- owner  out  1  index of current/last granted master

Behaviour:
- Reset (async, immediate): state=IDLE; mem_en=mem_we=0; mem_adr=mem_wdata=0; m0/m1_ack=0; m0/m1_rdata=0; owner=0; round-robin pointer set so master 0 wins the first tie.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE: requests sampled at the clock edge.
  - No request: stay in IDLE.
  - One request: grant that master.
  - Both requesting: round-robin grants the master not served last; with FIXED_PRI=1, master 0 is granted.
  - At grant: latch we/adr/wdata of the winner, set owner, go to ACCESS.
- ACCESS (exactly 1 cycle): mem_en=1, mem_we=latched we, mem_adr/mem_wdata=latched values.
  - Read: go to WAIT.
  - Write: go to RESP.
- WAIT (exactly RD_LAT cycles, down-counter): mem_en=0.
  - mem_rdata is captured into the owner's rdata register at the edge ending the last WAIT cycle.
  - Then go to RESP.
- RESP (1 cycle): owner's ack=1, other ack=0. Update the round-robin pointer. Go to IDLE.
- Latency, with the request sampled at the edge ending IDLE cycle t:
  - Read: ack in cycle t+2+RD_LAT.
  - Write: ack in cycle t+2.
  - Minimum spacing between transactions: 3 cycles (write), 3+RD_LAT cycles (read).
- Requester rules: req/we/adr/wdata are stable from assertion until ack.
  - Changes after the grant edge are ignored (latched copy is used).
  - req must be low in the cycle after ack unless a new transaction is intended. The cycle after RESP is IDLE, which samples req.
- rdata: each port's rdata changes only on completion of its own read and holds otherwise. Writes and the other master's reads never modify it.
- mem_adr/mem_wdata hold latched values outside ACCESS. mem_we=0 outside ACCESS.
- A request arriving while busy waits; it is never dropped and never acked twice.
- Reset mid-transaction (any state): the transaction is abandoned, no ack, all outputs return to reset values in the same cycle. Memory sees no further strobe.

Test Plan:
- Reset: assert rst with m0_req=1 pending -> all outputs 0, busy=0; after release, the first grant goes to master 0.
- Master 0 read, RD_LAT=1: m0_adr=0x0000_0040 at t, memory returns 0xDEADBEEF -> mem_en=1, mem_adr=0x40 in t+1; m0_ack=1 in t+3; m0_rdata=0xDEADBEEF held thereafter.
- Master 1 write: adr=0x100, wdata=0x12345678 -> mem_en=mem_we=1 for one cycle with those values; m1_ack in t+2; m1_rdata unchanged.
- Contention: both req held continuously with reads -> service order m0,m1,m0,m1, with owner toggling. With FIXED_PRI=1 -> only m0 served while m0_req stays high.
- Latch check, RD_LAT=3: m0 read of 0x200; change m0_adr to 0x300 after the grant edge -> mem_adr stays 0x200; ack at t+5.
- Reset asserted during WAIT -> mem_en=0, busy=0, no ack in following cycles; a subsequent m1 read completes normally.

Source files
------------

// File: rtl/mem_arb.sv
// mem_arb: two-master arbiter and sequencer for the unified memory port.
// Master 0 is the CPU, master 1 the debug/loader port; one access at a time.
module mem_arb #(
    parameter int RD_LAT    = 1,
    parameter int FIXED_PRI = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_adr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_ack,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_adr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_ack,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_adr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        owner
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [2:0] cnt;
    logic       lat_we;
    logic       last;
    logic       grant_m1;
    logic       any_req;
    logic       rd_done;

    assign any_req = m0_req | m1_req;
    assign rd_done = (state == WAIT) && (cnt == 3'd0);

    // Winner selection and next-state decode.
    always_comb begin
        grant_m1 = m1_req;
        if (m0_req && m1_req) begin
            grant_m1 = (FIXED_PRI != 0) ? 1'b0 : ~last;
        end
        state_nx = state;
        unique case (state)
            IDLE:    if (any_req) state_nx = ACCESS;
            ACCESS:  state_nx = lat_we ? RESP : WAIT;
            WAIT:    if (cnt == 3'd0) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Grant latch, wait counter and round-robin pointer (last served).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_we    <= 1'b0;
            mem_adr   <= '0;
            mem_wdata <= '0;
            owner     <= 1'b0;
            last      <= 1'b1;
            cnt       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        owner     <= grant_m1;
                        lat_we    <= grant_m1 ? m1_we : m0_we;
                        mem_adr   <= grant_m1 ? m1_adr : m0_adr;
                        mem_wdata <= grant_m1 ? m1_wdata : m0_wdata;
                    end
                end
                ACCESS:  cnt <= 3'(RD_LAT - 1);
                WAIT:    if (cnt != 3'd0) cnt <= cnt - 3'd1;
                RESP:    last <= owner;
                default: ;
            endcase
        end
    end

    // Read data lands only in the owning port's register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m0_rdata <= '0;
            m1_rdata <= '0;
        end else if (rd_done) begin
            if (owner) m1_rdata <= mem_rdata;
            else       m0_rdata <= mem_rdata;
        end
    end

    assign mem_en = (state == ACCESS);
    assign mem_we = mem_en & lat_we;
    assign busy   = (state != IDLE);
    assign m0_ack = (state == RESP) && !owner;
    assign m1_ack = (state == RESP) && owner;

endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: scoreboard bench for mem_arb.
// Instance 0: RD_LAT=1 round-robin. Instance 1: RD_LAT=3 fixed priority.
module tb_mem_arb;

    typedef struct packed {
        logic        m;
        logic        we;
        logic [31:0] adr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } txn_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    logic [3:0]        req = '0;
    logic [3:0]        we = '0;
    logic [3:0][31:0]  adr = '0;
    logic [3:0][31:0]  wdata = '0;
    wire  [3:0]        ack;
    wire  [3:0][31:0]  rdata;
    wire  [1:0]        en;
    wire  [1:0]        mwe;
    wire  [1:0]        busy;
    wire  [1:0]        owner;
    wire  [1:0][31:0]  madr;
    wire  [1:0][31:0]  mwd;
    wire  [1:0][31:0]  mrd;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] memval(input logic [31:0] a);
        case (a)
            32'h40:  return 32'hDEADBEEF;
            32'h200: return 32'hCAFE0200;
            32'h300: return 32'hBAD00300;
            default: return {16'h5A5A, a[15:0]};
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    for (genvar k = 0; k < 2; k++) begin : g
        localparam int LAT = (k == 0) ? 1 : 3;
        txn_t        aq[$];
        txn_t        rq[$];
        txn_t        t;
        int          acyc = 0;
        int          pend = 0;
        logic [31:0] padr = '0;

        mem_arb #(.RD_LAT(LAT), .FIXED_PRI(k)) dut (
            .clk(clk), .rst(rst),
            .m0_req(req[2*k]), .m0_we(we[2*k]),
            .m0_adr(adr[2*k]), .m0_wdata(wdata[2*k]),
            .m0_rdata(rdata[2*k]), .m0_ack(ack[2*k]),
            .m1_req(req[2*k+1]), .m1_we(we[2*k+1]),
            .m1_adr(adr[2*k+1]), .m1_wdata(wdata[2*k+1]),
            .m1_rdata(rdata[2*k+1]), .m1_ack(ack[2*k+1]),
            .mem_en(en[k]), .mem_we(mwe[k]),
            .mem_adr(madr[k]), .mem_wdata(mwd[k]),
            .mem_rdata(mrd[k]),
            .busy(busy[k]), .owner(owner[k])
        );

        // memory model: data valid only in the cycle LAT after capture
        always @(posedge clk) begin
            if (en[k] && !mwe[k]) begin
                pend <= LAT;
                padr <= madr[k];
            end else if (pend > 0) begin
                pend <= pend - 1;
            end
        end
        assign mrd[k] = (pend == 1) ? memval(padr) : 32'hBAD0_BAD0;

        always @(negedge clk) begin
            if (rst) begin
                aq.delete();
                rq.delete();
            end else begin
                if (en[k]) begin
                    if (aq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL strobe%0d: unexpected mem_en adr %h, want none",
                                 k, madr[k]);
                    end else begin
                        t = aq.pop_front();
                        chk("owner", 32'(owner[k]), 32'(t.m));
                        chk("mem_we", 32'(mwe[k]), 32'(t.we));
                        chk("mem_adr", madr[k], t.adr);
                        if (t.we) chk("mem_wdata", mwd[k], t.wdata);
                        acyc = cyc;
                        rq.push_back(t);
                    end
                end
                if (ack[2*k] || ack[2*k+1]) begin
                    if (rq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL ack%0d: unexpected ack %b, want none",
                                 k, {ack[2*k+1], ack[2*k]});
                    end else begin
                        t = rq.pop_front();
                        chk("ack_port", 32'({ack[2*k+1], ack[2*k]}),
                            t.m ? 32'd2 : 32'd1);
                        chk("ack_lat", 32'(cyc - acyc),
                            t.we ? 32'd1 : 32'(1 + LAT));
                        if (!t.we)
                            chk("rdata", rdata[2*k + int'(t.m)], t.rdata);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_txn(input int k, input logic m, input logic w,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] r);
        txn_t x;
        x.m = m;
        x.we = w;
        x.adr = a;
        x.wdata = d;
        x.rdata = r;
        if (k == 0) g[0].aq.push_back(x);
        else        g[1].aq.push_back(x);
    endtask

    task automatic drive(input int i, input logic w, input logic [31:0] a,
                         input logic [31:0] d);
        we[i] = w;
        adr[i] = a;
        wdata[i] = d;
        req[i] = 1'b1;
    endtask

    task automatic wait_ack(input int i, input int lim, input int c0,
                            output int lat);
        bit got = 0;
        for (int n = 0; n < lim && !got; n++) begin
            @(negedge clk);
            if (ack[i]) got = 1;
        end
        lat = cyc - c0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout port %0d: got no ack, want ack", i);
        end
    endtask

    initial begin
        int lat;
        int c0;
        int seen;

        #2 rst = 1'b1;
        drive(0, 1'b0, 32'h44, 32'h0);
        drive(1, 1'b0, 32'h80, 32'h0);
        tick(2);
        chk("rst mem_en", 32'(en[0]), 32'd0);
        chk("rst mem_we", 32'(mwe[0]), 32'd0);
        chk("rst mem_adr", madr[0], 32'd0);
        chk("rst mem_wdata", mwd[0], 32'd0);
        chk("rst acks", 32'({ack[1], ack[0]}), 32'd0);
        chk("rst m0_rdata", rdata[0], 32'd0);
        chk("rst m1_rdata", rdata[1], 32'd0);
        chk("rst busy", 32'(busy[0]), 32'd0);
        chk("rst owner", 32'(owner[0]), 32'd0);

        expect_txn(0, 1'b0, 1'b0, 32'h44, 32'h0, 32'h5A5A0044);
        expect_txn(0, 1'b1, 1'b0, 32'h80, 32'h0, 32'h5A5A0080);
        rst = 1'b0;
        wait_ack(0, 20, cyc, lat);
        req[0] = 1'b0;
        wait_ack(1, 20, cyc, lat);
        req[1] = 1'b0;
        tick(1);

        c0 = cyc;
        drive(0, 1'b0, 32'h40, 32'h0);
        expect_txn(0, 1'b0, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF);
        wait_ack(0, 20, c0, lat);
        req[0] = 1'b0;
        chk("m0 read latency", 32'(lat), 32'd3);
        tick(3);
        chk("m0 rdata held", rdata[0], 32'hDEADBEEF);

        c0 = cyc;
        drive(1, 1'b1, 32'h100, 32'h12345678);
        expect_txn(0, 1'b1, 1'b1, 32'h100, 32'h12345678, 32'h0);
        wait_ack(1, 20, c0, lat);
        req[1] = 1'b0;
        chk("m1 write latency", 32'(lat), 32'd2);
        tick(2);
        chk("m1 rdata after write", rdata[1], 32'h5A5A0080);
        chk("m0 rdata after m1 write", rdata[0], 32'hDEADBEEF);

        expect_txn(0, 1'b0, 1'b0, 32'h10, 32'h0, 32'h5A5A0010);
        expect_txn(0, 1'b1, 1'b0, 32'h20, 32'h0, 32'h5A5A0020);
        expect_txn(0, 1'b0, 1'b0, 32'h18, 32'h0, 32'h5A5A0018);
        expect_txn(0, 1'b1, 1'b0, 32'h28, 32'h0, 32'h5A5A0028);
        fork
            begin
                int l0;
                drive(0, 1'b0, 32'h10, 32'h0);
                wait_ack(0, 30, cyc, l0);
                drive(0, 1'b0, 32'h18, 32'h0);
                wait_ack(0, 30, cyc, l0);
                req[0] = 1'b0;
            end
            begin
                int l1;
                drive(1, 1'b0, 32'h20, 32'h0);
                wait_ack(1, 30, cyc, l1);
                drive(1, 1'b0, 32'h28, 32'h0);
                wait_ack(1, 30, cyc, l1);
                req[1] = 1'b0;
            end
        join
        tick(1);

        c0 = cyc;
        drive(2, 1'b0, 32'h200, 32'h0);
        expect_txn(1, 1'b0, 1'b0, 32'h200, 32'h0, 32'hCAFE0200);
        tick(1);
        adr[2] = 32'h300;
        wait_ack(2, 20, c0, lat);
        req[2] = 1'b0;
        chk("latched read latency", 32'(lat), 32'd5);
        chk("mem_adr hold", madr[1], 32'h200);
        tick(1);

        expect_txn(1, 1'b0, 1'b0, 32'h204, 32'h0, 32'h5A5A0204);
        expect_txn(1, 1'b0, 1'b0, 32'h208, 32'h0, 32'h5A5A0208);
        expect_txn(1, 1'b1, 1'b0, 32'h20C, 32'h0, 32'h5A5A020C);
        fork
            begin
                int l2;
                drive(2, 1'b0, 32'h204, 32'h0);
                wait_ack(2, 30, cyc, l2);
                drive(2, 1'b0, 32'h208, 32'h0);
                wait_ack(2, 30, cyc, l2);
                req[2] = 1'b0;
            end
            begin
                int l3;
                drive(3, 1'b0, 32'h20C, 32'h0);
                wait_ack(3, 40, cyc, l3);
                req[3] = 1'b0;
            end
        join
        tick(1);

        drive(2, 1'b0, 32'h210, 32'h0);
        expect_txn(1, 1'b0, 1'b0, 32'h210, 32'h0, 32'h5A5A0210);
        tick(2);
        chk("busy in WAIT", 32'(busy[1]), 32'd1);
        rst = 1'b1;
        req[2] = 1'b0;
        #1;
        chk("mid rst mem_en", 32'(en[1]), 32'd0);
        chk("mid rst busy", 32'(busy[1]), 32'd0);
        chk("mid rst acks", 32'({ack[3], ack[2]}), 32'd0);
        chk("mid rst m0_rdata", rdata[2], 32'd0);
        chk("mid rst owner", 32'(owner[1]), 32'd0);
        tick(2);
        rst = 1'b0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (ack[2] || ack[3] || en[1]) seen++;
        end
        chk("no activity after rst", 32'(seen), 32'd0);

        tick(1);
        c0 = cyc;
        drive(3, 1'b0, 32'h214, 32'h0);
        expect_txn(1, 1'b1, 1'b0, 32'h214, 32'h0, 32'h5A5A0214);
        wait_ack(3, 20, c0, lat);
        req[3] = 1'b0;
        chk("m1 read after rst latency", 32'(lat), 32'd5);
        tick(3);
        chk("scoreboard drained",
            32'(g[0].aq.size() + g[0].rq.size() +
                g[1].aq.size() + g[1].rq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
